siu_to_l2_mon: RTL

SIU_TO_L2_MON -- requirements
Module: siu_to_l2_mon

---
 rtl/siu_l2_mon_pkg.sv | 31 +++
 rtl/siu_to_l2_mon_if.sv | 27 ++
 rtl/siu_to_l2_bank_trk.sv | 142 ++++++++++++++
 rtl/siu_to_l2_mon.sv | 53 +++++
 4 files changed

// File: rtl/siu_l2_mon_pkg.sv
// SIU->L2 monitor: shared encodings, FSM states and beat counts.
// Imported by the bank tracker, its interface and the monitor top.
package siu_l2_mon_pkg;

   localparam int NUM_BANKS = 8;

   localparam logic [1:0] CMD_RD   = 2'b00;
   localparam logic [1:0] CMD_WR8  = 2'b01;
   localparam logic [1:0] CMD_WR64 = 2'b10;
   localparam logic [1:0] CMD_RSV  = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR1 = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [4:0] BEATS_WR8  = 5'd2;
   localparam logic [4:0] BEATS_WR64 = 5'd16;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [15:0] ctag;
   } hdr_t;

   function automatic hdr_t hdr_of(logic [31:0] w);
      hdr_t h;
      h.cmd  = w[31:30];
      h.ctag = w[15:0];
      return h;
   endfunction

endpackage

// File: rtl/siu_to_l2_mon_if.sv
// Per-bank bundle between the monitor top (master) and a bank tracker.
// Carries the request beat and dequeue in, completion and errors out.
interface siu_to_l2_mon_if;

   logic        vld;
   logic [31:0] req;
   logic        deq;
   logic        done;
   logic [1:0]  cmd;
   logic [15:0] ctag;
   logic [4:0]  cnt;
   logic        ovf;
   logic        udf;
   logic        ecmd;
   logic        gap;

   modport master (
      output vld, req, deq,
      input  done, cmd, ctag, cnt, ovf, udf, ecmd, gap
   );

   modport slave (
      input  vld, req, deq,
      output done, cmd, ctag, cnt, ovf, udf, ecmd, gap
   );

endinterface

// File: rtl/siu_to_l2_bank_trk.sv
// One L2 bank: packet framing FSM, completion pulse, input-queue
// occupancy count and sticky error flags.
module siu_to_l2_bank_trk
   import siu_l2_mon_pkg::*;
#(
   parameter int IQ_DEPTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   siu_to_l2_mon_if.slave    bus
);

   localparam logic [4:0] IQ_MAX = 5'(IQ_DEPTH);

   logic [1:0]  st_q, st_d;
   logic [4:0]  bc_q, bc_d;
   hdr_t        hdr_q, hdr_d;
   logic        done_q, done_d;
   logic [1:0]  pcmd_q, pcmd_d;
   logic [15:0] ptag_q, ptag_d;
   logic [4:0]  iq_q, iq_d;
   logic        ovf_q, ovf_d;
   logic        udf_q, udf_d;
   logic        ecmd_q, ecmd_d;
   logic        gap_q, gap_d;
   logic        fin;

   always_comb begin
      st_d   = st_q;
      bc_d   = bc_q;
      hdr_d  = hdr_q;
      done_d = 1'b0;
      pcmd_d = pcmd_q;
      ptag_d = ptag_q;
      iq_d   = iq_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      ecmd_d = ecmd_q;
      gap_d  = gap_q;
      fin    = 1'b0;
      if (en_i) begin
         unique case (1'b1)
            (st_q == ST_IDLE): begin
               if (bus.vld) begin
                  hdr_d = hdr_of(bus.req);
                  if (hdr_d.cmd == CMD_RSV) ecmd_d = 1'b1;
                  else                      st_d   = ST_HDR1;
               end
            end
            (st_q == ST_HDR1): begin
               if (!bus.vld) begin
                  gap_d = 1'b1;
                  st_d  = ST_IDLE;
               end else begin
                  unique case (1'b1)
                     (hdr_q.cmd == CMD_RD): fin = 1'b1;
                     (hdr_q.cmd == CMD_WR8): begin
                        st_d = ST_DATA;
                        bc_d = BEATS_WR8;
                     end
                     default: begin
                        st_d = ST_DATA;
                        bc_d = BEATS_WR64;
                     end
                  endcase
               end
            end
            (st_q == ST_DATA): begin
               if (!bus.vld) begin
                  gap_d = 1'b1;
                  st_d  = ST_IDLE;
                  bc_d  = 5'd0;
               end else begin
                  bc_d = bc_q - 5'd1;
                  if (bc_q == 5'd1) fin = 1'b1;
               end
            end
            default: st_d = ST_IDLE;
         endcase

         if (fin) begin
            done_d = 1'b1;
            pcmd_d = hdr_q.cmd;
            ptag_d = hdr_q.ctag;
            st_d   = ST_IDLE;
         end

         // Count follows the registered pulse, so a dequeue in the
         // pulse cycle cancels it out at either boundary.
         case ({done_q, bus.deq})
            2'b10: begin
               if (iq_q == IQ_MAX) ovf_d = 1'b1;
               else                iq_d  = iq_q + 5'd1;
            end
            2'b01: begin
               if (iq_q == 5'd0) udf_d = 1'b1;
               else              iq_d  = iq_q - 5'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q   <= ST_IDLE;
         bc_q   <= 5'd0;
         hdr_q  <= '0;
         done_q <= 1'b0;
         pcmd_q <= 2'd0;
         ptag_q <= 16'd0;
         iq_q   <= 5'd0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
         ecmd_q <= 1'b0;
         gap_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         bc_q   <= bc_d;
         hdr_q  <= hdr_d;
         done_q <= done_d;
         pcmd_q <= pcmd_d;
         ptag_q <= ptag_d;
         iq_q   <= iq_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
         ecmd_q <= ecmd_d;
         gap_q  <= gap_d;
      end
   end

   assign bus.done = done_q;
   assign bus.cmd  = pcmd_q;
   assign bus.ctag = ptag_q;
   assign bus.cnt  = iq_q;
   assign bus.ovf  = ovf_q;
   assign bus.udf  = udf_q;
   assign bus.ecmd = ecmd_q;
   assign bus.gap  = gap_q;

endmodule

// File: rtl/siu_to_l2_mon.sv
// SIU->L2 request monitor: eight independent bank trackers plus the
// flat bus slicing and the global error summary.
module siu_to_l2_mon
   import siu_l2_mon_pkg::*;
#(
   parameter int IQ_DEPTH = 16
) (
   input  logic                    iol2clk,
   input  logic                    rst,
   input  logic                    enabled,
   input  logic [NUM_BANKS-1:0]    sii_l2t_req_vld,
   input  logic [32*NUM_BANKS-1:0] sii_l2t_req,
   input  logic [NUM_BANKS-1:0]    l2t_sii_iq_dequeue,
   output logic [NUM_BANKS-1:0]    pkt_done,
   output logic [2*NUM_BANKS-1:0]  pkt_cmd,
   output logic [16*NUM_BANKS-1:0] pkt_ctag,
   output logic [5*NUM_BANKS-1:0]  iq_cnt,
   output logic [NUM_BANKS-1:0]    err_ovf,
   output logic [NUM_BANKS-1:0]    err_udf,
   output logic [NUM_BANKS-1:0]    err_cmd,
   output logic [NUM_BANKS-1:0]    err_gap,
   output logic                    err_any
);

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      siu_to_l2_mon_if bif ();

      assign bif.vld = sii_l2t_req_vld[g];
      assign bif.req = sii_l2t_req[32*g +: 32];
      assign bif.deq = l2t_sii_iq_dequeue[g];

      siu_to_l2_bank_trk #(
         .IQ_DEPTH (IQ_DEPTH)
      ) u_trk (
         .clk_i (iol2clk),
         .rst_i (rst),
         .en_i  (enabled),
         .bus   (bif.slave)
      );

      assign pkt_done[g]          = bif.done;
      assign pkt_cmd[2*g +: 2]    = bif.cmd;
      assign pkt_ctag[16*g +: 16] = bif.ctag;
      assign iq_cnt[5*g +: 5]     = bif.cnt;
      assign err_ovf[g]           = bif.ovf;
      assign err_udf[g]           = bif.udf;
      assign err_cmd[g]           = bif.ecmd;
      assign err_gap[g]           = bif.gap;
   end

   assign err_any = |{err_ovf, err_udf, err_cmd, err_gap};

endmodule
